pc_and_ir_concatenate: RTL and testbench
========================================

PC_AND_IR_CONCATENATE -- requirements
Module: PCandIR_Concatenate

Interface
REQ-001 Parameter PC_BITS, default 2: width of the upper program-counter field.
REQ-002 Parameter IR_BITS, default 14: width of the shifted instruction-immediate field.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port CLK, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-005 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port LeftShiftedIR, input, IR_BITS: IR immediate, already shifted left.
REQ-007 Port TwoBitsPC, input, PC_BITS: upper bits of the current PC.
REQ-008 Port Load, input, 1 bit: capture strobe for the registered target.
REQ-009 Port ConcatenatedOutput, output, PC_BITS+IR_BITS: combinational jump target.
REQ-010 Port RegisteredOutput, output, PC_BITS+IR_BITS: last captured jump target.
REQ-011 Port Valid, output, 1 bit: RegisteredOutput holds a capture made since reset.
REQ-012 Port AlignErr, output, 1 bit: registered misalignment flag (see Configuration).

Function
REQ-013 ConcatenatedOutput SHALL equal {TwoBitsPC, LeftShiftedIR}, with TwoBitsPC in the MSBs and LeftShiftedIR in the LSBs, with no truncation, sign extension or padding.
REQ-014 ConcatenatedOutput SHALL be purely combinational: no clock dependence and no dependence on Reset, Load or internal state.
REQ-015 On a rising CLK edge with Reset=0 and Load=1, RegisteredOutput SHALL take the current ConcatenatedOutput value and Valid SHALL become 1; capture latency is one cycle.
REQ-016 With Load=0, RegisteredOutput, Valid and AlignErr SHALL hold their values.
REQ-017 Back-to-back Load cycles SHALL capture a new value every cycle; no handshake or backpressure exists.
REQ-018 Input changes between edges SHALL affect only ConcatenatedOutput, never the registered outputs.

Reset
REQ-019 With Reset=1 at a rising CLK edge, RegisteredOutput SHALL become 0, Valid SHALL become 0 and AlignErr SHALL become 0.
REQ-020 Reset SHALL take priority over a simultaneous Load.
REQ-021 Reset SHALL have no effect on ConcatenatedOutput.

Configuration
REQ-022 Macro CONCAT_ALIGN_CHECK_EN: when defined, each Load capture SHALL set AlignErr to LeftShiftedIR[0], because a correctly shifted immediate has LSB 0.
REQ-023 When CONCAT_ALIGN_CHECK_EN is defined, AlignErr SHALL NOT alter ConcatenatedOutput or RegisteredOutput; misaligned values pass through unchanged.
REQ-024 When CONCAT_ALIGN_CHECK_EN is not defined, AlignErr SHALL be constant 0 and no checking logic SHALL be built.

Verification
REQ-025 LeftShiftedIR=14'h3FFF, TwoBitsPC=2'b10, wait 100 ns -> ConcatenatedOutput=16'hBFFF.
REQ-026 After REQ-025, set LeftShiftedIR=0 with TwoBitsPC held at 2'b10, wait 100 ns -> ConcatenatedOutput=16'h8000.
REQ-027 Reset=1 for one edge, then Load=1 with inputs 2'b01 and 14'h1234 -> after that edge RegisteredOutput=16'h5234 and Valid=1; with Load=0 and new inputs, RegisteredOutput stays 16'h5234.
REQ-028 Reset=1 and Load=1 on the same edge -> RegisteredOutput=0 and Valid=0.
REQ-029 With CONCAT_ALIGN_CHECK_EN defined, Load 14'h0001 -> AlignErr=1, and RegisteredOutput equals the concatenation unchanged; without the macro, AlignErr=0.
REQ-030 Sweep all 4 TwoBitsPC values with random LeftShiftedIR -> ConcatenatedOutput[15:14]=TwoBitsPC and ConcatenatedOutput[13:0]=LeftShiftedIR every time.

Source files
------------

// File: rtl/pc_and_ir_concatenate.sv
// Jump-target builder: {PC upper bits, shifted IR immediate}, plus an optionally captured copy.
// Optional feature macro: CONCAT_ALIGN_CHECK_EN (flags captures whose immediate LSB is set).
module pc_and_ir_concatenate #(
  parameter int PC_BITS = 2,
  parameter int IR_BITS = 14
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [IR_BITS-1:0]         LeftShiftedIR,
  input  logic [PC_BITS-1:0]         TwoBitsPC,
  input  logic                       Load,
  output logic [PC_BITS+IR_BITS-1:0] ConcatenatedOutput,
  output logic [PC_BITS+IR_BITS-1:0] RegisteredOutput,
  output logic                       Valid,
  output logic                       AlignErr
);

  localparam int OUT_BITS = PC_BITS + IR_BITS;

  logic [OUT_BITS-1:0] target_q, target_d;
  logic                valid_q, valid_d;

  // The target is a pure wire: Reset, Load and stored state never touch it.
  assign ConcatenatedOutput = {TwoBitsPC, LeftShiftedIR};

  always_comb begin
    target_d = target_q;
    valid_d  = valid_q;
    if (Load) begin
      target_d = ConcatenatedOutput;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      target_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      target_q <= target_d;
      valid_q  <= valid_d;
    end
  end

  assign RegisteredOutput = target_q;
  assign Valid            = valid_q;

`ifdef CONCAT_ALIGN_CHECK_EN
  logic align_q, align_d;

  // A correctly shifted immediate always has LSB 0; the value itself is passed through untouched.
  always_comb begin
    align_d = align_q;
    if (Load) begin
      align_d = LeftShiftedIR[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      align_q <= 1'b0;
    end else begin
      align_q <= align_d;
    end
  end

  assign AlignErr = align_q;
`else
  assign AlignErr = 1'b0;
`endif

endmodule

// File: tb/tb_pc_and_ir_concatenate.sv
// Randomized self-checking bench for pc_and_ir_concatenate against an arithmetic reference model.
module tb_pc_and_ir_concatenate;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [13:0] LeftShiftedIR;
  logic [1:0]  TwoBitsPC;
  logic        Load;
  logic [15:0] ConcatenatedOutput;
  logic [15:0] RegisteredOutput;
  logic        Valid;
  logic        AlignErr;

  int total = 0;
  int bad   = 0;

  // Reference state: what the registered outputs should hold.
  int unsigned exp_reg   = 0;
  int unsigned exp_valid = 0;
  int unsigned exp_align = 0;

  pc_and_ir_concatenate #(.PC_BITS(2), .IR_BITS(14)) dut (
    .CLK                (CLK),
    .Reset              (Reset),
    .LeftShiftedIR      (LeftShiftedIR),
    .TwoBitsPC          (TwoBitsPC),
    .Load               (Load),
    .ConcatenatedOutput (ConcatenatedOutput),
    .RegisteredOutput   (RegisteredOutput),
    .Valid              (Valid),
    .AlignErr           (AlignErr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end else begin
      $display("ok   %s: value=%0h", tag, got);
    end
  endtask

  function automatic int unsigned target_of(input int unsigned pc, input int unsigned ir);
    return pc * 16384 + ir;
  endfunction

  // One clock: drive at negedge, check the wire, clock it, update model, check registers.
  task automatic step(input bit rst, input bit ld, input int unsigned pc, input int unsigned ir);
    @(negedge CLK);
    Reset         = rst;
    Load          = ld;
    TwoBitsPC     = pc[1:0];
    LeftShiftedIR = ir[13:0];
    #1;
    check("concat", ConcatenatedOutput, target_of(pc, ir));
    @(posedge CLK);
    if (rst) begin
      exp_reg = 0; exp_valid = 0; exp_align = 0;
    end else if (ld) begin
      exp_reg   = target_of(pc, ir);
      exp_valid = 1;
`ifdef CONCAT_ALIGN_CHECK_EN
      exp_align = ir % 2;
`endif
    end
    #1;
    check("regout", RegisteredOutput, exp_reg);
    check("valid", Valid, exp_valid);
    check("alignerr", AlignErr, exp_align);
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; TwoBitsPC = 2'b00; LeftShiftedIR = 14'h0;

    // Reset state
    step(1'b1, 1'b0, 0, 0);

    // Combinational target, independent of the clock
    TwoBitsPC = 2'b10; LeftShiftedIR = 14'h3FFF;
    #100;
    check("concat_bfff", ConcatenatedOutput, 32'hBFFF);
    LeftShiftedIR = 14'h0000;
    #100;
    check("concat_8000", ConcatenatedOutput, 32'h8000);

    // Capture then hold with new inputs
    step(1'b1, 1'b0, 2, 0);
    step(1'b0, 1'b1, 1, 14'h1234);
    check("cap_5234", RegisteredOutput, 32'h5234);
    step(1'b0, 1'b0, 3, 14'h2AAA);
    check("hold_5234", RegisteredOutput, 32'h5234);

    // Reset beats a simultaneous Load
    step(1'b0, 1'b1, 2, 14'h0F0F);
    step(1'b1, 1'b1, 3, 14'h3FFE);

    // Misaligned immediate passes through unchanged
    step(1'b0, 1'b1, 0, 14'h0001);
    check("misalign_pass", RegisteredOutput, 32'h0001);

    // Back-to-back loads
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, $urandom_range(0, 16383));

    // Sweep all PC values with random immediates
    for (int pc = 0; pc < 4; pc++) begin
      for (int k = 0; k < 4; k++) begin
        int unsigned ir;
        ir = $urandom_range(0, 16383);
        TwoBitsPC = pc[1:0]; LeftShiftedIR = ir[13:0];
        #3;
        check("sweep_hi", int'(ConcatenatedOutput[15:14]), pc);
        check("sweep_lo", int'(ConcatenatedOutput[13:0]), ir);
      end
    end

    // Randomized mix of reset, load and idle cycles
    for (int n = 0; n < 200; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3), $urandom_range(0, 16383));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
